// File: rtl/alu_operand_stage.sv
// alu_operand_stage: execute-entry pipeline register feeding the ALU.
// Resolves operands (register file / immediate / EX or WB bypass),
// stalls upstream on load-use hazards, and presents a registered
// oper/a/b/rd bundle to the ALU with a valid/ready handshake.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             drop held and incoming op (branch redirect)
//   in_valid/in_ready upstream handshake
//   in_oper           ALU operation, passed through unmodified
//   in_ra_idx/data    source A index and register-file data
//   in_rb_idx/data    source B index and register-file data
//   in_rd_idx         destination register index
//   in_use_imm/imm    select immediate as operand B
//   ex_valid/is_load  EX stage register-writing op / load
//   ex_rd_idx/data    EX destination and result
//   wb_valid          WB stage writing a register
//   wb_rd_idx/data    WB destination and write data
//   out_valid/ready   downstream handshake to the ALU
//   out_oper/a/b      registered operation and resolved operands
//   out_rd_idx        registered destination
//   stall_count       saturating count of stalled request cycles

module alu_operand_stage #(
    parameter int DATA_WIDTH      = 32,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int OPER_WIDTH      = 4,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OPER_WIDTH-1:0]      in_oper,
    input  logic [REG_IDX_WIDTH-1:0]   in_ra_idx,
    input  logic [REG_IDX_WIDTH-1:0]   in_rb_idx,
    input  logic [REG_IDX_WIDTH-1:0]   in_rd_idx,
    input  logic [DATA_WIDTH-1:0]      in_ra_data,
    input  logic [DATA_WIDTH-1:0]      in_rb_data,
    input  logic                       in_use_imm,
    input  logic [DATA_WIDTH-1:0]      in_imm,
    input  logic                       ex_valid,
    input  logic                       ex_is_load,
    input  logic [REG_IDX_WIDTH-1:0]   ex_rd_idx,
    input  logic [DATA_WIDTH-1:0]      ex_data,
    input  logic                       wb_valid,
    input  logic [REG_IDX_WIDTH-1:0]   wb_rd_idx,
    input  logic [DATA_WIDTH-1:0]      wb_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OPER_WIDTH-1:0]      out_oper,
    output logic [DATA_WIDTH-1:0]      out_a,
    output logic [DATA_WIDTH-1:0]      out_b,
    output logic [REG_IDX_WIDTH-1:0]   out_rd_idx,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = '1;

    logic                  ex_fwd_ok;
    logic                  ex_load_pending;
    logic                  hit_a;
    logic                  hit_b;
    logic                  hazard;
    logic                  accept;
    logic                  consume;
    logic                  stall;
    logic [DATA_WIDTH-1:0] opnd_a;
    logic [DATA_WIDTH-1:0] opnd_b;

    // A non-load EX result is ready to bypass; a load is not.
    assign ex_fwd_ok       = ex_valid & ~ex_is_load;
    assign ex_load_pending = ex_valid & ex_is_load & (ex_rd_idx != '0);

    // With an immediate, rb is not a real source and must not stall.
    assign hit_a  = (ex_rd_idx == in_ra_idx);
    assign hit_b  = ~in_use_imm & (ex_rd_idx == in_rb_idx);
    assign hazard = in_valid & ex_load_pending & (hit_a | hit_b);

    assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid & out_ready;
    assign stall    = in_valid & ~in_ready & ~flush;

    // Operand A: r0 is zero, then EX (younger) over WB, then RF.
    always_comb begin
        opnd_a = in_ra_data;
        if (in_ra_idx == '0) begin
            opnd_a = '0;
        end else if (ex_fwd_ok && ex_rd_idx == in_ra_idx) begin
            opnd_a = ex_data;
        end else if (wb_valid && wb_rd_idx == in_ra_idx) begin
            opnd_a = wb_data;
        end
    end

    // Operand B: same priority, immediate overrides everything.
    always_comb begin
        opnd_b = in_rb_data;
        if (in_use_imm) begin
            opnd_b = in_imm;
        end else if (in_rb_idx == '0) begin
            opnd_b = '0;
        end else if (ex_fwd_ok && ex_rd_idx == in_rb_idx) begin
            opnd_b = ex_data;
        end else if (wb_valid && wb_rd_idx == in_rb_idx) begin
            opnd_b = wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    // Payload loads only on capture; held values are never re-forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_oper   <= '0;
            out_a      <= '0;
            out_b      <= '0;
            out_rd_idx <= '0;
        end else if (accept) begin
            out_oper   <= in_oper;
            out_a      <= opnd_a;
            out_b      <= opnd_b;
            out_rd_idx <= in_rd_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && stall_count != STALL_MAX) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Execute-entry pipeline register that sits directly upstream of the ALU.
- Captures decoded ops from the register-read stage and resolves operands: register file, immediate, or bypass from the EX/WB results.
- Detects load-use hazards and stalls upstream.
- Presents registered oper/a/b to the ALU with a valid/ready handshake.

Parameters:
DATA_WIDTH, 32, width of operands and forwarded results (ALU in/out width)
REG_IDX_WIDTH, 4, register index width (16 GPRs; r0 hardwired zero)
OPER_WIDTH, 4, width of ALU operation code (passed through unmodified)
STALL_CNT_WIDTH, 16, width of saturating stall counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  discard held and incoming op (branch redirect)
in_valid  input  1  upstream op valid
in_ready  output  1  stage can accept op this cycle
in_oper  input  OPER_WIDTH  ALU operation
in_ra_idx  input  REG_IDX_WIDTH  source A register index
in_rb_idx  input  REG_IDX_WIDTH  source B register index
in_rd_idx  input  REG_IDX_WIDTH  destination register index
in_ra_data  input  DATA_WIDTH  register-file read data A
in_rb_data  input  DATA_WIDTH  register-file read data B
in_use_imm  input  1  1: operand B = in_imm
in_imm  input  DATA_WIDTH  sign/zero-extended immediate (extension done upstream)
ex_valid  input  1  EX stage holds a reg-writing op
ex_is_load  input  1  EX op is a load (data not yet available)
ex_rd_idx  input  REG_IDX_WIDTH  EX destination
ex_data  input  DATA_WIDTH  EX result (ALU out.data)
wb_valid  input  1  WB stage writing a register
wb_rd_idx  input  REG_IDX_WIDTH  WB destination
wb_data  input  DATA_WIDTH  WB write data
out_valid  output  1  registered op valid to ALU
out_ready  input  1  ALU/EX consumes op this cycle
out_oper  output  OPER_WIDTH  registered operation
out_a  output  DATA_WIDTH  resolved operand A
out_b  output  DATA_WIDTH  resolved operand B
out_rd_idx  output  REG_IDX_WIDTH  registered destination
stall_count  output  STALL_CNT_WIDTH  cycles with in_valid=1 and in_ready=0 (saturating)

Behaviour:
- Reset (async, rst=1): out_valid=0; out_oper, out_a, out_b, out_rd_idx=0; stall_count=0. Reset mid-operation drops the held op with no residue.
- Operand A resolution, combinational, at capture:
  - idx==0 -> 0.
  - else ex_valid & !ex_is_load & ex_rd_idx==idx -> ex_data.
  - else wb_valid & wb_rd_idx==idx -> wb_data.
  - else in_ra_data.
- Operand B: same rule using in_rb_idx/in_rb_data; if in_use_imm=1, B = in_imm and in_rb_idx is ignored for forwarding and hazard.
- EX has priority over WB when both match (EX is younger).
- hazard = in_valid & ex_valid & ex_is_load & ex_rd_idx!=0 & (ex_rd_idx==in_ra_idx | (!in_use_imm & ex_rd_idx==in_rb_idx)).
- in_ready = (!out_valid | out_ready) & !hazard & !flush; combinational, no dependence on in_valid except through hazard.
- Next-state priority, per clock:
  1. flush: out_valid<=0 and incoming op dropped, regardless of in_valid/out_ready.
  2. in_valid & in_ready: capture resolved op, out_valid<=1.
  3. out_valid & out_ready (no capture): out_valid<=0.
  4. Otherwise hold. Operands are frozen while held; no re-forwarding.
- Data registers load only on capture; they keep their last values when out_valid=0.
- Latency: 1 cycle from accept to out_valid. Back-to-back throughput is 1 op/cycle when out_ready=1 and there is no hazard.
- Simultaneous consume + accept: the new op replaces the old one in the same edge; out_valid stays 1.
- Hazard with output empty: out_valid<=0 (bubble inserted); in_ready stays 0 until the EX load retires.
- stall_count increments when in_valid=1 & in_ready=0 & !flush; it saturates at all-ones and never wraps.
- out_oper is passed through unmodified; any oper encoding, including unused ones, is accepted.

Test Plan:
- Basic pass: in add, ra=3 (data 0x10), rb=4 (data 0x20), no fwd -> next cycle out_valid=1, out_a=0x10, out_b=0x20, out_rd_idx=rd.
- Forward priority: ra=5, ex_rd_idx=5 ex_data=0xAAAA, wb_rd_idx=5 wb_data=0xBBBB, in_ra_data=0xCCCC -> out_a=0xAAAA. Drop ex_valid -> out_a=0xBBBB. Set ra=0 -> out_a=0 with all forwards matching.
- Load-use: ex_is_load=1, ex_rd_idx=7, in_ra_idx=7 -> in_ready=0, out_valid goes 0, stall_count +1 per cycle. Clear ex_is_load -> accepted next edge. Repeat with in_use_imm=1, rb_idx=7, ra_idx=2 -> no stall.
- Backpressure: out_ready=0 for 3 cycles with op held -> out_a/out_b unchanged despite wb_data changes; in_ready=0. Release -> new op captured on the same edge the old one is consumed.
- Flush + reset: flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and incoming op lost. Assert rst asynchronously mid-hold -> outputs 0 immediately, before the clock edge.
- Saturation: force STALL_CNT_WIDTH=4 and hold hazard 20 cycles -> stall_count=15 and stays 15.
